// File: rtl/i2s2_master_if.sv
// Sample-stream side of the Pmod I2S2 master:
// DAC holding-register handshake and ADC capture results.
interface i2s2_master_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] tx_left;
    logic [DATA_W-1:0] tx_right;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_underrun;
    logic [DATA_W-1:0] rx_left;
    logic [DATA_W-1:0] rx_right;
    logic              rx_valid;

    modport master (
        input  tx_left, tx_right, tx_valid,
        output tx_ready, tx_underrun,
        output rx_left, rx_right, rx_valid
    );

    modport slave (
        output tx_left, tx_right, tx_valid,
        input  tx_ready, tx_underrun,
        input  rx_left, rx_right, rx_valid
    );
endinterface

// File: rtl/i2s2_master.sv
// I2S master for the Pmod I2S2: 64 SCLK per frame, Philips format,
// one shared clock set for DAC line-out and ADC line-in.
module i2s2_master #(
    parameter int MCLK_DIV   = 2,
    parameter int BCLK_RATIO = 4,
    parameter int DATA_W     = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    i2s2_master_if.master  bus,
    output logic           lineout_mclk,
    output logic           lineout_lrck,
    output logic           lineout_sclk,
    output logic           lineout_sdout,
    output logic           linein_mclk,
    output logic           linein_lrck,
    output logic           linein_sclk,
    input  logic           linein_sdin
);
    localparam int BP    = MCLK_DIV * BCLK_RATIO;
    localparam int FRAME = 64 * BP;
    localparam int CW    = $clog2(FRAME);
    localparam logic [CW-1:0] FRAME_MAX = CW'(FRAME - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tick, accept;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [DATA_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic [DATA_W-1:0] cap_l_q, cap_l_d, cap_r_q, cap_r_d;
    logic [DATA_W-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
    logic              rx_valid_q, underrun_q;
    logic              mclk_q, mclk_d, sclk_q, sclk_d;
    logic              lrck_q, lrck_d, sdout_q, sdout_d;
    int                nxt, nslot, cur, cslot;

    assign tick   = (cnt_q == FRAME_MAX);
    assign cnt_d  = tick ? '0 : cnt_q + CW'(1);
    assign accept = bus.tx_valid && !hold_full_q;

    // Pin flops are driven from the next count so they line up with cnt_q.
    assign nxt   = int'(cnt_d);
    assign nslot = (nxt / BP) % 32;
    assign cur   = int'(cnt_q);
    assign cslot = (cur / BP) % 32;

    always_comb begin
        mclk_d  = (nxt % MCLK_DIV) >= (MCLK_DIV / 2);
        sclk_d  = (nxt % BP) >= (BP / 2);
        lrck_d  = (nxt / BP) >= 32;
        sdout_d = sdout_q;
        sh_l_d  = sh_l_q;
        sh_r_d  = sh_r_q;
        if (tick) begin
            sh_l_d  = hold_full_q ? hold_l_q : '0;
            sh_r_d  = hold_full_q ? hold_r_q : '0;
            sdout_d = 1'b0;
        end else if ((nxt % BP) == 0) begin
            sdout_d = 1'b0;
            if (nslot >= 1 && nslot <= DATA_W) begin
                if (lrck_d) begin
                    sdout_d = sh_r_q[DATA_W-1];
                    sh_r_d  = sh_r_q << 1;
                end else begin
                    sdout_d = sh_l_q[DATA_W-1];
                    sh_l_d  = sh_l_q << 1;
                end
            end
        end
    end

    always_comb begin
        cap_l_d = cap_l_q;
        cap_r_d = cap_r_q;
        if ((cur % BP) == (BP / 2) && cslot >= 1 && cslot <= DATA_W) begin
            if ((cur / BP) >= 32)
                cap_r_d = (cap_r_q << 1) | DATA_W'(linein_sdin);
            else
                cap_l_d = (cap_l_q << 1) | DATA_W'(linein_sdin);
        end
        rx_l_d = tick ? cap_l_q : rx_l_q;
        rx_r_d = tick ? cap_r_q : rx_r_q;
    end

    // A tick with an empty holding register still accepts a same-cycle pair.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        if (tick && hold_full_q) begin
            hold_full_d = 1'b0;
        end else if (accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = bus.tx_left;
            hold_r_d    = bus.tx_right;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            sh_l_q      <= '0;
            sh_r_q      <= '0;
            cap_l_q     <= '0;
            cap_r_q     <= '0;
            rx_l_q      <= '0;
            rx_r_q      <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            mclk_q      <= 1'b0;
            sclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            sdout_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            sh_l_q      <= sh_l_d;
            sh_r_q      <= sh_r_d;
            cap_l_q     <= cap_l_d;
            cap_r_q     <= cap_r_d;
            rx_l_q      <= rx_l_d;
            rx_r_q      <= rx_r_d;
            rx_valid_q  <= tick;
            underrun_q  <= tick && !hold_full_q;
            mclk_q      <= mclk_d;
            sclk_q      <= sclk_d;
            lrck_q      <= lrck_d;
            sdout_q     <= sdout_d;
        end
    end

    assign bus.tx_ready    = !hold_full_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.rx_left     = rx_l_q;
    assign bus.rx_right    = rx_r_q;
    assign bus.rx_valid    = rx_valid_q;

    assign lineout_mclk  = mclk_q;
    assign lineout_lrck  = lrck_q;
    assign lineout_sclk  = sclk_q;
    assign lineout_sdout = sdout_q;
    assign linein_mclk   = mclk_q;
    assign linein_lrck   = lrck_q;
    assign linein_sclk   = sclk_q;
endmodule

// File: tb/tb_i2s2_master.sv
// Directed bench for i2s2_master with SDOUT looped back to SDIN;
// expected capture words queue up as stimulus is driven.
module tb_i2s2_master;
    localparam int DW = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic lo_mclk, lo_lrck, lo_sclk, lo_sdout;
    logic li_mclk, li_lrck, li_sclk, li_sdin;

    i2s2_master_if #(.DATA_W(DW)) bus ();

    i2s2_master #(
        .MCLK_DIV(2),
        .BCLK_RATIO(4),
        .DATA_W(DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .lineout_mclk(lo_mclk),
        .lineout_lrck(lo_lrck),
        .lineout_sclk(lo_sclk),
        .lineout_sdout(lo_sdout),
        .linein_mclk(li_mclk),
        .linein_lrck(li_lrck),
        .linein_sclk(li_sclk),
        .linein_sdin(li_sdin)
    );

    assign li_sdin = lo_sdout;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int tcnt     = 0;
    int mon_slot;
    logic prev_sdout = 1'b0;
    logic [2*DW-1:0] sb[$];
    logic [2*DW-1:0] mon_e;
    logic [DW-1:0] wl = 24'hA5A5A5;
    logic [DW-1:0] wr = 24'h5A5A5A;
    logic [DW-1:0] val;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference position within the 512-cycle frame
    always @(posedge clk or negedge rst_n)
        if (!rst_n) tcnt <= 0;
        else tcnt <= (tcnt == 511) ? 0 : tcnt + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mclk", 32'(lo_mclk), (tcnt % 2 == 1) ? 1 : 0);
            chk("sclk", 32'(lo_sclk), (tcnt % 8 >= 4) ? 1 : 0);
            chk("lrck", 32'(lo_lrck), (tcnt >= 256) ? 1 : 0);
            chk("linein_clks", 32'({li_mclk, li_lrck, li_sclk}),
                32'({lo_mclk, lo_lrck, lo_sclk}));
            if (tcnt % 8 != 0)
                chk("sdout_hold", 32'(lo_sdout), 32'(prev_sdout));
            mon_slot = (tcnt / 8) % 32;
            if (mon_slot == 0 || mon_slot > DW)
                chk("sdout_pad", 32'(lo_sdout), 0);
            if (bus.rx_valid) begin
                chk("rx_expected", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("rx_left", 32'(bus.rx_left), 32'(mon_e[2*DW-1:DW]));
                    chk("rx_right", 32'(bus.rx_right), 32'(mon_e[DW-1:0]));
                end
            end
        end
        prev_sdout = lo_sdout;
    end

    task automatic wait_cnt(input int target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tcnt != target && n < 1100);
        chk("wait_cnt", tcnt, target);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(bus.tx_ready), 1);
        chk({tag, "_underrun"}, 32'(bus.tx_underrun), 0);
        chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 0);
        chk({tag, "_rx_left"}, 32'(bus.rx_left), 0);
        chk({tag, "_rx_right"}, 32'(bus.rx_right), 0);
        chk({tag, "_pins"}, 32'({lo_mclk, lo_lrck, lo_sclk, lo_sdout}), 0);
        chk({tag, "_in_pins"}, 32'({li_mclk, li_lrck, li_sclk}), 0);
    endtask

    initial begin
        int n_acc, n_und, n_rxv, n_sd, e;
        logic acc;
        bus.tx_valid = 1'b0;
        bus.tx_left  = '0;
        bus.tx_right = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        sb.push_back('0);

        // Push one pair in frame 0; it goes out in frame 1
        wait_cnt(10);
        chk("ready_idle", 32'(bus.tx_ready), 1);
        bus.tx_left  = wl;
        bus.tx_right = wr;
        bus.tx_valid = 1'b1;
        sb.push_back({wl, wr});
        @(negedge clk);
        chk("ready_full", 32'(bus.tx_ready), 0);
        bus.tx_valid = 1'b0;
        bus.tx_left  = '0;
        bus.tx_right = '0;
        wait_cnt(511);
        chk("ready_before_tick", 32'(bus.tx_ready), 0);
        wait_cnt(0);
        chk("ready_after_tick", 32'(bus.tx_ready), 1);
        chk("no_underrun_f1", 32'(bus.tx_underrun), 0);

        for (int s = 0; s < 64; s++) begin
            wait_cnt(s * 8 + 4);
            e = 0;
            if (s >= 1 && s <= DW) e = 32'(wl[DW-s]);
            else if (s >= 33 && s <= 32 + DW) e = 32'(wr[32+DW-s]);
            chk("sdout_slot", 32'(lo_sdout), e);
        end

        // Idle frames underrun once per frame
        sb.push_back('0);
        wait_cnt(0);
        chk("underrun_f2", 32'(bus.tx_underrun), 1);
        @(negedge clk);
        chk("underrun_f2_end", 32'(bus.tx_underrun), 0);
        sb.push_back('0);
        wait_cnt(0);
        chk("underrun_f3", 32'(bus.tx_underrun), 1);
        wait_cnt(200);
        chk("underrun_mid", 32'(bus.tx_underrun), 0);
        sb.push_back('0);
        wait_cnt(0);
        chk("underrun_f4", 32'(bus.tx_underrun), 1);

        // tx_valid held high with incrementing data
        val = 24'd1;
        bus.tx_left  = val;
        bus.tx_right = ~val;
        bus.tx_valid = 1'b1;
        for (int f = 0; f < 3; f++) begin
            n_acc = 0;
            n_und = 0;
            for (int c = 0; c < 512; c++) begin
                acc = bus.tx_ready;
                if (acc) sb.push_back({val, ~val});
                @(negedge clk);
                if (bus.tx_underrun) n_und++;
                if (acc) begin
                    n_acc++;
                    val = val + 24'd1;
                    bus.tx_left  = val;
                    bus.tx_right = ~val;
                end
            end
            chk("accepts_per_frame", n_acc, 1);
            chk("underruns_streaming", n_und, 0);
        end
        bus.tx_valid = 1'b0;

        // Reset mid-frame with a held pair
        wait_cnt(0);
        wait_cnt(10);
        bus.tx_left  = 24'h123456;
        bus.tx_right = 24'h654321;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        chk("ready_held", 32'(bus.tx_ready), 0);
        wait_cnt(300);
        rst_n = 1'b0;
        #1;
        chk_reset_state("midreset");
        chk("sb_drained", sb.size(), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('0);
        n_rxv = 0;
        n_sd  = 0;
        for (int c = 0; c < 511; c++) begin
            @(negedge clk);
            if (bus.rx_valid) n_rxv++;
            if (lo_sdout) n_sd++;
        end
        chk("no_rx_partial", n_rxv, 0);
        chk("sdout_zero_after_reset", n_sd, 0);
        @(negedge clk);
        chk("rx_valid_after_reset", 32'(bus.rx_valid), 1);
        chk("underrun_discarded", 32'(bus.tx_underrun), 1);
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
